// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

   // Owner of the memory port in the previous cycle
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU      = 2'd1,
      AUX      = 2'd2,
      AUX_LOCK = 2'd3
   } arb_state_t;

   // Memory-side mux select: CPU is the default when nobody is granted
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_AUX = 1'b1;

   // Default bound on consecutive locked aux grants
   localparam int MAX_LOCK_DEF = 8;

endpackage

// File: rtl/dmem_arb_lock_cnt.sv
// Saturating lock counter: load 1, increment up to MAX_LOCK, else clear.
module dmem_arb_lock_cnt #(
   parameter int MAX_LOCK = dmem_arb_pkg::MAX_LOCK_DEF,
   parameter int CNT_W    = $clog2(MAX_LOCK + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_one,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_reg;

   // Counter update; any cycle without set or inc clears the count
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (set_one) begin
         cnt_reg <= CNT_W'(1);
      end else if (inc) begin
         if (cnt_reg != CNT_W'(MAX_LOCK)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end else begin
         cnt_reg <= '0;
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Zero-latency arbiter sharing the data-memory port between the CPU and an
// auxiliary master. Optional performance counters: define DMEM_ARB_PERF_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = MAX_LOCK_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic              aux_lock,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_gnt,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
`ifdef DMEM_ARB_PERF_EN
   output logic [31:0]       perf_cpu_stall_cnt,
   output logic [31:0]       perf_aux_gnt_cnt,
`endif
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   arb_state_t       state_reg;
   arb_state_t       state_next;
   logic [CNT_W-1:0] lock_cnt;
   logic             aux_wins;
   logic             owner_sel;
   logic             lock_set;
   logic             lock_inc;

   // Owner register; only the previous cycle's winner is remembered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Contention resolution, grants and next owner
   always_comb begin
      aux_wins   = 1'b0;
      state_next = IDLE;
      // Who would win if both requested: lock holds until the budget is spent,
      // otherwise alternate with the CPU taking the first slot out of IDLE/AUX
      if (state_reg == AUX_LOCK) begin
         aux_wins = (lock_cnt < CNT_W'(MAX_LOCK));
      end else begin
         aux_wins = (state_reg == CPU);
      end
      cpu_gnt = cpu_req & ~(aux_req & aux_wins);
      aux_gnt = aux_req & ~(cpu_req & ~aux_wins);
      if (cpu_gnt) begin
         state_next = CPU;
      end else if (aux_gnt) begin
         state_next = aux_lock ? AUX_LOCK : AUX;
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;
   assign lock_inc  = aux_gnt & (state_reg == AUX_LOCK);
   assign lock_set  = aux_gnt & aux_lock & (state_reg != AUX_LOCK);

   dmem_arb_lock_cnt #(
      .MAX_LOCK (MAX_LOCK),
      .CNT_W    (CNT_W)
   ) u_lock_cnt (
      .clk     (clk),
      .rst     (rst),
      .set_one (lock_set),
      .inc     (lock_inc),
      .cnt     (lock_cnt)
   );

   // Memory-side mux; aux only drives the port on its own grant
   assign owner_sel = aux_gnt ? OWN_AUX : OWN_CPU;
   assign mem_addr  = (owner_sel == OWN_AUX) ? aux_addr  : cpu_addr;
   assign mem_wdata = (owner_sel == OWN_AUX) ? aux_wdata : cpu_wdata;
   assign mem_we    = (cpu_gnt & cpu_we) | (aux_gnt & aux_we);
   assign rdata     = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_stall_reg;
   logic [31:0] perf_aux_reg;

   // Free-running event counters, wrapping naturally at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_reg <= '0;
         perf_aux_reg   <= '0;
      end else begin
         if (cpu_stall) perf_stall_reg <= perf_stall_reg + 32'd1;
         if (aux_gnt)   perf_aux_reg   <= perf_aux_reg + 32'd1;
      end
   end

   assign perf_cpu_stall_cnt = perf_stall_reg;
   assign perf_aux_gnt_cnt   = perf_aux_reg;
`endif

endmodule
